// File: rtl/adder_tb_pkg.sv
// Shared encodings and constants for the adder stimulus pre-processor.
package adder_tb_pkg;

  typedef enum logic [1:0] {
    MODE_SWEEP  = 2'd0,
    MODE_LFSR   = 2'd1,
    MODE_CORNER = 2'd2,
    MODE_WALK   = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
  } corner_t;

  // Overflow, carry and sign-boundary cases for an 8-bit adder.
  localparam corner_t CORNER_TBL [8] = '{
    '{8'h00, 8'h00, 1'b0},
    '{8'hFF, 8'h01, 1'b0},
    '{8'h7F, 8'h01, 1'b0},
    '{8'h80, 8'h80, 1'b0},
    '{8'hFF, 8'hFF, 1'b1},
    '{8'h7F, 8'h7F, 1'b1},
    '{8'h80, 8'h7F, 1'b1},
    '{8'h55, 8'hAA, 1'b1}
  };

  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/adder_preproc_if.sv
// Operand vector stream. Handshake: a vector moves on every rising clk edge where
// out_valid & out_ready; while out_valid & ~out_ready the producer holds a/b/ci stable.
interface adder_preproc_if #(parameter int W = 8);
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] a_out;
  logic [W-1:0] b_out;
  logic         ci_out;

  modport master (output out_valid, a_out, b_out, ci_out, input out_ready);
  modport slave  (input out_valid, a_out, b_out, ci_out, output out_ready);
endinterface

// File: rtl/adder_vecgen.sv
// Combinational operand generator: maps (mode, step counter, lfsr) to one vector.
module adder_vecgen
  import adder_tb_pkg::*;
#(
  parameter int W = 8
) (
  input  mode_t        mode,
  input  logic [2*W:0] g,
  input  logic [15:0]  lfsr,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic         ci
);

  // Walking-one indexing assumes W is a power of two.
  localparam int LW = $clog2(W);

  corner_t ent;

  always_comb begin
    ent = CORNER_TBL[g[2:0]];
    a   = '0;
    b   = '0;
    ci  = 1'b0;
    case (mode)
      MODE_SWEEP:  {a, b, ci} = g;
      MODE_LFSR: begin
        a  = W'(lfsr[15:8]);
        b  = W'(lfsr[7:0]);
        ci = lfsr[15] ^ lfsr[0];
      end
      MODE_CORNER: begin
        a  = W'(ent.a);
        b  = W'(ent.b);
        ci = ent.ci;
      end
      MODE_WALK: begin
        a  = W'(1) << g[LW-1:0];
        b  = ~a;
        ci = g[LW];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/adder_preproc.sv
// Stimulus sequencer: on start, streams count_n operand vectors of the chosen mode
// to the adder under test, then pulses done.
module adder_preproc
  import adder_tb_pkg::*;
#(
  parameter int          W         = 8,
  parameter int          CNT_W     = 16,
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] count_n,
  adder_preproc_if.master  bus,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] vec_idx,
  output state_t           dbg_state
);

  state_t           state_q, state_d;
  mode_t            mode_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] idx_q;
  logic [2*W:0]     g_q;
  logic [15:0]      lfsr_q;
  logic             accept;
  logic             xfer;
  logic [W-1:0]     gen_a, gen_b;
  logic             gen_ci;

  assign accept = (state_q == ST_IDLE) && start;
  assign xfer   = (state_q == ST_RUN) && bus.out_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = (count_n == '0) ? ST_DONE : ST_RUN;
      ST_RUN: begin
        // A transfer coinciding with abort still counts; either ends the run.
        if (abort || (xfer && (idx_q + CNT_W'(1) == count_q))) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_SWEEP;
      count_q <= '0;
      idx_q   <= '0;
      g_q     <= '0;
      lfsr_q  <= LFSR_SEED;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mode_q  <= mode_t'(mode);
        count_q <= count_n;
        idx_q   <= '0;
        g_q     <= '0;
        lfsr_q  <= LFSR_SEED;
      end else if (xfer) begin
        idx_q  <= idx_q + CNT_W'(1);
        g_q    <= g_q + (2*W+1)'(1);
        lfsr_q <= lfsr_next(lfsr_q);
      end
    end
  end

  adder_vecgen #(.W(W)) u_vecgen (
    .mode (mode_q),
    .g    (g_q),
    .lfsr (lfsr_q),
    .a    (gen_a),
    .b    (gen_b),
    .ci   (gen_ci)
  );

  // Operands read as zero whenever no vector is offered.
  assign bus.out_valid = (state_q == ST_RUN);
  assign bus.a_out     = bus.out_valid ? gen_a : '0;
  assign bus.b_out     = bus.out_valid ? gen_b : '0;
  assign bus.ci_out    = bus.out_valid ? gen_ci : 1'b0;

  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign vec_idx   = idx_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_adder_preproc.sv
// Self-checking bench for adder_preproc: scenario tasks plus a scoreboard monitor.
module tb_adder_preproc;
  import adder_tb_pkg::*;

  localparam int W     = 8;
  localparam int CNT_W = 16;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic [CNT_W-1:0] count_n = '0;
  logic             busy, done;
  logic [CNT_W-1:0] vec_idx;
  state_t           dbg_state;

  always #5 clk = ~clk;

  adder_preproc_if #(.W(W)) bus ();

  adder_preproc #(.W(W), .CNT_W(CNT_W), .LFSR_SEED(16'hACE1)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .mode      (mode),
    .count_n   (count_n),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .vec_idx   (vec_idx),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [2*W:0] exp_q[$];
  int n_cmp = 0, n_err = 0;
  int cyc = 0, xfer_cnt = 0, done_cnt = 0, valid_cnt = 0, busy_cnt = 0;
  int done_cyc = -1, last_xfer_cyc = -1;

  // ---------------- reference model ----------------
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic fb;
    fb = l[15] ^ l[13] ^ l[12] ^ l[10];
    return {l[14:0], fb};
  endfunction

  function automatic logic [16:0] corner_entry(input int i);
    case (i)
      0: return {8'h00, 8'h00, 1'b0};
      1: return {8'hFF, 8'h01, 1'b0};
      2: return {8'h7F, 8'h01, 1'b0};
      3: return {8'h80, 8'h80, 1'b0};
      4: return {8'hFF, 8'hFF, 1'b1};
      5: return {8'h7F, 8'h7F, 1'b1};
      6: return {8'h80, 8'h7F, 1'b1};
      default: return {8'h55, 8'hAA, 1'b1};
    endcase
  endfunction

  function automatic logic [16:0] model_vec(input int m, input int g, input logic [15:0] l);
    logic [7:0]  a;
    logic [16:0] gv;
    case (m)
      0: begin gv = 17'(g % 131072); return gv; end
      1: return {l[15:8], l[7:0], l[15] ^ l[0]};
      2: return corner_entry(g % 8);
      default: begin
        a = 8'h01 << (g % 8);
        return {a, ~a, 1'((g / 8) % 2)};
      end
    endcase
  endfunction

  task automatic push_run(input int m, input int n);
    logic [15:0] l;
    l = 16'hACE1;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(model_vec(m, i, l));
      l = lfsr_step(l);
    end
  endtask

  // ---------------- monitor (scoreboard consumer) ----------------
  task automatic monitor();
    logic        stall = 1'b0;
    logic [16:0] prev = '0;
    logic [16:0] v, e;
    forever begin
      @(negedge clk);
      cyc++;
      v = {bus.a_out, bus.b_out, bus.ci_out};
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (busy) busy_cnt++;
      if (bus.out_valid) valid_cnt++;
      if (stall && !rst) begin
        n_cmp++;
        if (!bus.out_valid || v !== prev) begin
          n_err++;
          $display("FAIL hold_stable: got valid=%0b vec=%h, expected valid=1 vec=%h",
                   bus.out_valid, v, prev);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        xfer_cnt++;
        last_xfer_cyc = cyc;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_xfer: got vec=%h, expected no transfer", v);
        end else begin
          e = exp_q.pop_front();
          if (v !== e) begin
            n_err++;
            $display("FAIL scoreboard: got vec=%h, expected %h", v, e);
          end
        end
      end
      stall = bus.out_valid && !bus.out_ready;
      prev  = v;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_run(input logic [1:0] m, input int n);
    @(posedge clk); #1;
    mode    = m;
    count_n = CNT_W'(n);
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_held_ctrl: got valid=%0b busy=%0b done=%0b, expected 0/0/0",
               bus.out_valid, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (dbg_state !== ST_IDLE) begin
      n_err++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
    end
    n_cmp++;
    if (vec_idx !== '0) begin
      n_err++; $display("FAIL reset_vec_idx: got %0d expected 0", vec_idx);
    end
    n_cmp++;
    if ({bus.a_out, bus.b_out, bus.ci_out} !== 17'h0) begin
      n_err++; $display("FAIL reset_operands: got %h expected 0", {bus.a_out, bus.b_out, bus.ci_out});
    end
    n_cmp++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got valid=%0b busy=%0b done=%0b, expected 0/0/0",
               bus.out_valid, busy, done);
    end
  endtask

  task automatic test_sweep();
    bit ok;
    int c0, d0;
    bus.out_ready = 1'b1;
    d0 = done_cnt;
    push_run(0, 4);
    start_run(2'd0, 4);
    c0 = cyc;
    wait_done(20, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL sweep_timeout: got no done, expected done"); end
    n_cmp++;
    if (vec_idx !== 16'd4) begin n_err++; $display("FAIL sweep_vec_idx: got %0d expected 4", vec_idx); end
    n_cmp++;
    if (last_xfer_cyc !== c0 + 4) begin
      n_err++; $display("FAIL sweep_b2b: got last xfer cycle %0d expected %0d", last_xfer_cyc, c0 + 4);
    end
    n_cmp++;
    if (done_cyc !== c0 + 5) begin
      n_err++; $display("FAIL sweep_done_time: got cycle %0d expected %0d", done_cyc, c0 + 5);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (done_cnt - d0 !== 1) begin
      n_err++; $display("FAIL sweep_done_pulse: got %0d done cycles expected 1", done_cnt - d0);
    end
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_err++; $display("FAIL sweep_drain: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic test_corner();
    bit ok;
    int x0;
    bus.out_ready = 1'b1;
    x0 = xfer_cnt;
    push_run(2, 10);
    start_run(2'd2, 10);
    wait_done(40, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL corner_timeout: got no done, expected done"); end
    n_cmp++;
    if (vec_idx !== 16'd10) begin n_err++; $display("FAIL corner_vec_idx: got %0d expected 10", vec_idx); end
    n_cmp++;
    if (xfer_cnt - x0 !== 10) begin
      n_err++; $display("FAIL corner_xfers: got %0d expected 10", xfer_cnt - x0);
    end
  endtask

  task automatic test_lfsr_stall();
    bit ok;
    int d0, x0;
    logic [16:0] v;
    bus.out_ready = 1'b0;
    d0 = done_cnt;
    x0 = xfer_cnt;
    push_run(1, 3);
    start_run(2'd1, 3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      v = {bus.a_out, bus.b_out, bus.ci_out};
      n_cmp++;
      if (bus.out_valid !== 1'b1 || v !== {8'hAC, 8'hE1, 1'b0}) begin
        n_err++;
        $display("FAIL lfsr_stall_vec: got valid=%0b vec=%h, expected valid=1 vec=%h",
                 bus.out_valid, v, {8'hAC, 8'hE1, 1'b0});
      end
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_done(20, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL lfsr_timeout: got no done, expected done"); end
    @(negedge clk); #1;
    n_cmp++;
    if (xfer_cnt - x0 !== 3 || vec_idx !== 16'd3) begin
      n_err++; $display("FAIL lfsr_count: got xfers=%0d vec_idx=%0d expected 3/3", xfer_cnt - x0, vec_idx);
    end
    n_cmp++;
    if (done_cnt - d0 !== 1) begin
      n_err++; $display("FAIL lfsr_done_pulse: got %0d expected 1", done_cnt - d0);
    end
  endtask

  task automatic test_zero_count();
    int d0, v0, b0;
    bus.out_ready = 1'b1;
    d0 = done_cnt; v0 = valid_cnt; b0 = busy_cnt;
    start_run(2'd0, 0);
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1) begin n_err++; $display("FAIL zero_done: got %0b expected 1", done); end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin n_err++; $display("FAIL zero_done_end: got %0b expected 0", done); end
    #1;
    n_cmp++;
    if (valid_cnt !== v0 || busy_cnt !== b0 || done_cnt - d0 !== 1) begin
      n_err++;
      $display("FAIL zero_activity: got valid_cyc=%0d busy_cyc=%0d done_cyc=%0d expected 0/0/1",
               valid_cnt - v0, busy_cnt - b0, done_cnt - d0);
    end
  endtask

  task automatic test_walk_abort();
    int x0;
    bus.out_ready = 1'b1;
    x0 = xfer_cnt;
    push_run(3, 6);
    start_run(2'd3, 20);
    repeat (5) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_ctrl: got valid=%0b done=%0b busy=%0b expected 0/1/0", bus.out_valid, done, busy);
    end
    n_cmp++;
    if (vec_idx !== 16'd6) begin n_err++; $display("FAIL abort_vec_idx: got %0d expected 6", vec_idx); end
    #1;
    n_cmp++;
    if (xfer_cnt - x0 !== 6 || exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL abort_xfers: got %0d xfers %0d pending expected 6/0", xfer_cnt - x0, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    ok = 1'b0;
    push_run(1, 25);
    start_run(2'd1, 25);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
      @(posedge clk); #1;
      bus.out_ready = 1'($urandom_range(0, 1));
      // A start during RUN carries a different mode and count and must be ignored.
      if (i == 4) begin start = 1'b1; mode = 2'd2; count_n = 16'd3; end
      else start = 1'b0;
    end
    #1;
    start = 1'b0;
    bus.out_ready = 1'b1;
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL b2b_timeout: got no done, expected done"); end
    n_cmp++;
    if (vec_idx !== 16'd25 || exp_q.size() !== 0) begin
      n_err++; $display("FAIL b2b_count: got vec_idx=%0d pending=%0d expected 25/0", vec_idx, exp_q.size());
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    int d0;
    bus.out_ready = 1'b1;
    push_run(0, 50);
    start_run(2'd0, 50);
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (vec_idx !== 16'd3) begin n_err++; $display("FAIL pre_reset_idx: got %0d expected 3", vec_idx); end
    d0 = done_cnt;
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || vec_idx !== '0) begin
      n_err++;
      $display("FAIL async_reset_ctrl: got valid=%0b busy=%0b done=%0b idx=%0d expected 0/0/0/0",
               bus.out_valid, busy, done, vec_idx);
    end
    n_cmp++;
    if ({bus.a_out, bus.b_out, bus.ci_out} !== 17'h0 || dbg_state !== ST_IDLE) begin
      n_err++;
      $display("FAIL async_reset_ops: got vec=%h state=%0d expected 0/%0d",
               {bus.a_out, bus.b_out, bus.ci_out}, dbg_state, ST_IDLE);
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (done_cnt !== d0) begin n_err++; $display("FAIL reset_no_done: got %0d pulses expected 0", done_cnt - d0); end
    push_run(0, 2);
    start_run(2'd0, 2);
    n_cmp++;
    if (vec_idx !== '0 || busy !== 1'b1) begin
      n_err++; $display("FAIL restart: got idx=%0d busy=%0b expected 0/1", vec_idx, busy);
    end
    wait_done(20, ok);
    n_cmp++;
    if (!ok || vec_idx !== 16'd2 || exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL restart_run: got done=%0b idx=%0d pending=%0d expected 1/2/0", ok, vec_idx, exp_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.out_ready = 1'b0;
    fork
      monitor();
    join_none
    test_reset();
    test_sweep();
    test_corner();
    test_lfsr_stall();
    test_zero_count();
    test_walk_abort();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

endmodule
